// File: rtl/seg7_scan_driver_pkg.sv
// Shared segment encodings for the multiplexed common-anode display path.
// SEG bit order is {g,f,e,d,c,b,a}; every pattern is active-low.
package seg7_scan_driver_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_drv_t;

  localparam seg_drv_t DRV_OFF = '{seg: SEG_OFF, dp: 1'b1};

endpackage

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Pure combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_to_seg7
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with
// ghost blanking, leading-zero blanking and a per-frame input snapshot.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   BCD,
  input  logic [DIGITS-1:0]     DP_MASK,
  input  logic                  LZB,
  input  logic                  EN,
  output logic [6:0]            SEG,
  output logic                  DP,
  output logic [DIGITS-1:0]     DIG
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0] PCNT_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK_INIT = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX    = IW'(DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [PW-1:0]         blank_q, blank_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   snap_q, snap_d;
  logic [DIGITS-1:0]     dig_q, dig_d;
  seg_drv_t              drv_q, drv_d;

  logic                  tick;
  logic [3:0]            cur_digit;
  logic [6:0]            cur_seg;
  logic [DIGITS-1:0]     zero_above;
  logic                  lz_run;
  logic                  lzb_dark;
  logic                  dark;

  assign tick = (pcnt_q == PCNT_MAX);

  always_comb begin
    pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
    idx_d   = idx_q;
    snap_d  = snap_q;
    blank_d = blank_q;
    if (tick) begin
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      blank_d = BLANK_INIT;
      // Snapshot at frame end so a whole frame always shows one value.
      if (idx_q == IDX_MAX) snap_d = BCD;
    end else if (blank_q != '0) begin
      blank_d = blank_q - PW'(1);
    end
  end

  // zero_above[k]: snapshot digits k..DIGITS-1 are all zero.
  always_comb begin
    zero_above = '0;
    lz_run     = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      lz_run        = lz_run && (snap_q[4*k +: 4] == 4'd0);
      zero_above[k] = lz_run;
    end
  end

  assign lzb_dark  = LZB && (idx_q != '0) && zero_above[idx_q];
  assign cur_digit = snap_q[{idx_q, 2'b00} +: 4];
  assign dark      = (blank_q != '0) || !EN || lzb_dark;

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_seg)
  );

  always_comb begin
    dig_d = '1;
    drv_d = DRV_OFF;
    if (!dark) begin
      dig_d[idx_q] = 1'b0;
      drv_d        = '{seg: cur_seg, dp: ~DP_MASK[idx_q]};
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pcnt_q  <= '0;
      idx_q   <= '0;
      blank_q <= '0;
      snap_q  <= '0;
      dig_q   <= '1;
      drv_q   <= DRV_OFF;
    end else begin
      pcnt_q  <= pcnt_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      snap_q  <= snap_d;
      dig_q   <= dig_d;
      drv_q   <= drv_d;
    end
  end

  assign SEG = drv_q.seg;
  assign DP  = drv_q.dp;
  assign DIG = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues the expected per-cycle display state, a
// negedge monitor pops and compares one entry per cycle.
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] BCD;
  logic [3:0]  DP_MASK;
  logic        LZB;
  logic        EN;
  logic [6:0]  SEG;
  logic        DP;
  logic [3:0]  DIG;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .BCD     (BCD),
    .DP_MASK (DP_MASK),
    .LZB     (LZB),
    .EN      (EN),
    .SEG     (SEG),
    .DP      (DP),
    .DIG     (DIG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         chk;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    int         scen;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   scen   = 0;

  task automatic check(input string nm, input logic [3:0] ad, input logic [6:0] as_,
                       input logic ap, input logic [3:0] ed, input logic [6:0] es,
                       input logic ep);
    checks++;
    if (ad !== ed || as_ !== es || ap !== ep) begin
      errors++;
      $display("FAIL %s: got DIG=%b SEG=%h DP=%b, want DIG=%b SEG=%h DP=%b",
               nm, ad, as_, ap, ed, es, ep);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.chk) check($sformatf("scen%0d t=%0t", e.scen, $time), DIG, SEG, DP, e.dig, e.seg, e.dp);
    end
  end

  task automatic push(input bit chk, input logic [3:0] dig, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.chk = chk; e.dig = dig; e.seg = seg; e.dp = dp; e.scen = scen;
    q.push_back(e);
  endtask

  task automatic push_dark(input bit chk);
    push(chk, 4'hF, 7'h7F, 1'b1);
  endtask

  task automatic push_dc_frame();
    for (int i = 0; i < 16; i++) push(1'b0, 4'hF, 7'h7F, 1'b1);
  endtask

  // seg is packed {digit3, digit2, digit1, digit0}.
  task automatic push_frame(input logic [3:0] lit, input logic [3:0][6:0] seg,
                            input logic [3:0] dpm);
    logic [3:0] d;
    for (int k = 0; k < 4; k++) begin
      d = 4'b0001 << k;
      d = ~d;
      push_dark(1'b1);
      for (int r = 0; r < 3; r++)
        if (lit[k]) push(1'b1, d, seg[k], ~dpm[k]);
        else        push_dark(1'b1);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge CLK); #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL wait_empty scen%0d: %0d entries left, want 0", scen, q.size());
      q.delete();
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; BCD = 16'h0000; DP_MASK = 4'b0000; LZB = 1'b1; EN = 1'b1;
    step(2);
    scen = 0;
    push_dark(1'b1);
    wait_empty();

    // Startup with snapshot 0 and LZB: only digit 0, first slot has no gap.
    RESET = 1'b1;
    scen = 1;
    push_dark(1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, 4'b1110, 7'h40, 1'b1);
    for (int i = 0; i < 12; i++) push_dark(1'b1);
    wait_empty();

    scen = 2; BCD = 16'h1234; LZB = 1'b0;
    push_dc_frame();
    push_frame(4'hF, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
    wait_empty();

    scen = 3; EN = 1'b0;
    push_dc_frame();
    push_frame(4'h0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000);
    wait_empty();

    scen = 4; EN = 1'b1; BCD = 16'h0090; LZB = 1'b1; DP_MASK = 4'b0010;
    push_dc_frame();
    push_frame(4'b0011, {7'h7F, 7'h7F, 7'h10, 7'h40}, 4'b0010);
    wait_empty();

    scen = 5; BCD = 16'h00A0; DP_MASK = 4'b0000;
    push_dc_frame();
    push_frame(4'b0011, {7'h7F, 7'h7F, 7'h3F, 7'h40}, 4'b0000);
    wait_empty();

    // Mid-frame BCD changes must not tear the frame in progress.
    scen = 6; BCD = 16'h0005; LZB = 1'b0;
    push_dc_frame();
    wait_empty();
    push_frame(4'hF, {7'h40, 7'h40, 7'h40, 7'h12}, 4'b0000);
    push_frame(4'hF, {7'h40, 7'h40, 7'h40, 7'h78}, 4'b0000);
    push_frame(4'hF, {7'h79, 7'h79, 7'h79, 7'h79}, 4'b0000);
    step(5);
    BCD = 16'h0007;
    step(16);
    BCD = 16'h1111;
    wait_empty();

    // Async reset while digit 2 is lit.
    scen = 7;
    push_dark(1'b1);
    for (int i = 0; i < 3; i++) push(1'b1, 4'b1110, 7'h79, 1'b1);
    push_dark(1'b1);
    for (int i = 0; i < 3; i++) push(1'b1, 4'b1101, 7'h79, 1'b1);
    push_dark(1'b1);
    push(1'b1, 4'b1011, 7'h79, 1'b1);
    step(9);
    #7;
    RESET = 1'b0;
    #1;
    check("reset_async", DIG, SEG, DP, 4'hF, 7'h7F, 1'b1);
    step(1);
    RESET = 1'b1;
    scen = 8;
    push_dark(1'b1);
    for (int i = 0; i < 4; i++) push(1'b1, 4'b1110, 7'h40, 1'b1);
    push_dark(1'b1);
    for (int i = 0; i < 3; i++) push(1'b1, 4'b1101, 7'h40, 1'b1);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
